lsu_bus: RTL

LSU_BUS -- requirements
Module: lsu_bus

---
 rtl/lsu_bus_pkg.sv | 28 ++
 rtl/lsu_bus.sv | 114 +++++++++++
 2 files changed

// File: rtl/lsu_bus_pkg.sv
// Shared types and constants for the load/store bus adapter.
package lsu_bus_pkg;

   localparam int unsigned TIMEOUT_DEFAULT = 255;
   localparam int unsigned DW              = 32;
   localparam int unsigned BEW             = 4;
   localparam int unsigned CNTW            = 8;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_RESP = 2'd2,
      ST_DONE = 2'd3
   } state_e;

   // Transaction payload captured when a request is accepted
   typedef struct packed {
      logic           we;
      logic [BEW-1:0] be;
      logic [DW-1:0]  wdata;
   } bus_pl_t;

   // Stores use their own byte enables; loads fetch the whole word
   function automatic logic [BEW-1:0] req_be(input logic [BEW-1:0] wen);
      return (wen != '0) ? wen : {BEW{1'b1}};
   endfunction

endpackage

// File: rtl/lsu_bus.sv
// Load/store unit bus adapter: turns one execute-stage memory access into a
// request/grant/response bus transaction and stalls the pipeline meanwhile.
module lsu_bus
   import lsu_bus_pkg::*;
#(
   parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT,
   parameter int unsigned AW      = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [31:0]     req_addr_i,
   input  logic [31:0]     req_wdata_i,
   input  logic [3:0]      req_wen_i,
   input  logic            req_ren_i,
   output logic [31:0]     rdata_o,
   output logic            hold_o,
   output logic            err_o,
   output logic            bus_req_o,
   output logic            bus_we_o,
   output logic [AW-1:0]   bus_addr_o,
   output logic [31:0]     bus_wdata_o,
   output logic [3:0]      bus_be_o,
   input  logic            bus_gnt_i,
   input  logic            bus_rvalid_i,
   input  logic [31:0]     bus_rdata_i
);

   state_e          state, state_d;
   logic [CNTW-1:0] cnt, cnt_d;
   logic [DW-1:0]   rdata_d;
   logic            err_d;
   logic            req_d;
   bus_pl_t         pl, pl_d;
   logic [AW-1:0]   addr_d;
   logic [AW-1:0]   word_addr;
   logic            pending;
   logic            complete;
   logic            timeout_hit;

   assign pending     = req_ren_i | (|req_wen_i);
   assign word_addr   = AW'(req_addr_i) & ~AW'(32'd3);
   assign timeout_hit = (cnt == CNTW'(TIMEOUT - 1));

   assign bus_we_o    = pl.we;
   assign bus_be_o    = pl.be;
   assign bus_wdata_o = pl.wdata;

   // Next-state, next register values and the combinational stall
   always_comb begin
      state_d  = state;
      cnt_d    = cnt;
      rdata_d  = rdata_o;
      err_d    = 1'b0;
      pl_d     = pl;
      addr_d   = bus_addr_o;
      hold_o   = 1'b0;
      complete = 1'b0;

      case (state)
         ST_IDLE: begin
            if (pending) begin
               hold_o   = ~rst;
               state_d  = ST_REQ;
               cnt_d    = '0;
               pl_d.we    = |req_wen_i;
               pl_d.be    = req_be(req_wen_i);
               pl_d.wdata = req_wdata_i;
               addr_d   = word_addr;
            end
         end
         ST_REQ, ST_RESP: begin
            hold_o   = 1'b1;
            cnt_d    = cnt + CNTW'(1);
            // A response only counts once the request is granted (same cycle allowed)
            complete = bus_rvalid_i && ((state == ST_RESP) || bus_gnt_i);
            if (complete) begin
               state_d = ST_DONE;
               if (!pl.we) rdata_d = bus_rdata_i;
            end else if (timeout_hit) begin
               state_d = ST_DONE;
               rdata_d = '0;
               err_d   = 1'b1;
            end else if ((state == ST_REQ) && bus_gnt_i) begin
               state_d = ST_RESP;
            end
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase

      req_d = (state_d == ST_REQ);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= ST_IDLE;
         cnt        <= '0;
         rdata_o    <= '0;
         err_o      <= 1'b0;
         bus_req_o  <= 1'b0;
         pl         <= '0;
         bus_addr_o <= '0;
      end else begin
         state      <= state_d;
         cnt        <= cnt_d;
         rdata_o    <= rdata_d;
         err_o      <= err_d;
         bus_req_o  <= req_d;
         pl         <= pl_d;
         bus_addr_o <= addr_d;
      end
   end

endmodule
